// File: rtl/pipe_pkg.sv
// Shared types and defaults for the skid-buffered pipeline stage.
package pipe_pkg;

  localparam int unsigned PIPE_DATA_WIDTH = 96;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with an optional skid register (PIPE_STAGE_SKID_EN).
// With the skid, in_ready_o is a flop; without it, in_ready_o follows out_ready_i.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH = PIPE_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0]  FLUSH_DATA = '0
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst_n,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o
);

  pipe_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic                  rdy_q, rdy_d;
  logic                  in_xfer_c;
  logic                  out_xfer_c;
`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
`endif

  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = main_q;

`ifdef PIPE_STAGE_SKID_EN
  assign in_ready_o = rdy_q;
`else
  // rdy_q only masks the ready during and right after reset
  assign in_ready_o = rdy_q && (!out_valid_o || out_ready_i);
`endif

  assign in_xfer_c  = in_valid_i && in_ready_o;
  assign out_xfer_c = out_valid_o && out_ready_i;

  // Next-state and datapath selection; flush overrides every handshake
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_d  = skid_q;
`endif
    case (state_q)
      EMPTY: begin
        if (in_xfer_c) begin
          state_d = ONE;
          main_d  = in_data_i;
        end
      end
      ONE: begin
        if (in_xfer_c) begin
          if (out_xfer_c) begin
            main_d = in_data_i;
          end
`ifdef PIPE_STAGE_SKID_EN
          else begin
            state_d = TWO;
            skid_d  = in_data_i;
          end
`endif
        end else if (out_xfer_c) begin
          state_d = EMPTY;
          main_d  = FLUSH_DATA;
        end
      end
`ifdef PIPE_STAGE_SKID_EN
      TWO: begin
        if (out_xfer_c) begin
          state_d = ONE;
          main_d  = skid_q;
          skid_d  = FLUSH_DATA;
        end
      end
`endif
      default: begin
        state_d = EMPTY;
        main_d  = FLUSH_DATA;
      end
    endcase
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = FLUSH_DATA;
`ifdef PIPE_STAGE_SKID_EN
      skid_d  = FLUSH_DATA;
`endif
    end
`ifdef PIPE_STAGE_SKID_EN
    rdy_d = (state_d != TWO);
`else
    rdy_d = 1'b1;
`endif
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      state_q <= EMPTY;
      main_q  <= FLUSH_DATA;
      rdy_q   <= 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      skid_q  <= FLUSH_DATA;
`endif
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      rdy_q   <= rdy_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_q  <= skid_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed vector table plus flush/reset sequences and a random scoreboard
// for pipe_stage_skid; expectations adapt to PIPE_STAGE_SKID_EN.
module tb_pipe_stage_skid;

  localparam int unsigned DW = 96;
  localparam logic [DW-1:0] FD = 96'h0000_0000_0000_0000_0000_F1F1;

  logic          cpu_clk;
  logic          cpu_rst_n;
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_stage_skid #(.DATA_WIDTH(DW), .FLUSH_DATA(FD)) dut (
    .cpu_clk    (cpu_clk),
    .cpu_rst_n  (cpu_rst_n),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    string         name;
    logic          flush;
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          ir_pre;
    logic          ov;
    logic [DW-1:0] od;
    logic          ir;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string name, logic f, logic iv, logic [DW-1:0] d, logic ordy,
                              logic ir_pre, logic ov, logic [DW-1:0] od, logic ir);
    vec_t v;
    v.name = name; v.flush = f; v.iv = iv; v.d = d; v.ordy = ordy;
    v.ir_pre = ir_pre; v.ov = ov; v.od = od; v.ir = ir;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic f, logic iv, logic [DW-1:0] d, logic ordy);
    flush_i = f; in_valid_i = iv; in_data_i = d; out_ready_i = ordy;
  endtask

  task automatic cyc(logic f, logic iv, logic [DW-1:0] d, logic ordy);
    drive(f, iv, d, ordy);
    #1;
    @(posedge cpu_clk);
    #1;
  endtask

  logic [DW-1:0] q[$];
  int in_cnt, out_cnt;

  initial begin
    cpu_rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);

    // Reset state and release
    cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    chk("rst_ov", out_valid_o, 0);
    chk("rst_od", out_data_o, FD);
    chk("rst_ir", in_ready_o, 0);
    cpu_rst_n = 1'b1;
    #1;
    chk("rel_ir_pre", in_ready_o, 0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    chk("rel_ir", in_ready_o, 1);
    chk("rel_ov", out_valid_o, 0);

    // Streaming 1..8
    for (int i = 1; i <= 8; i++)
      add($sformatf("stream%0d", i), 0, 1, DW'(i), 1, 1, 1, DW'(i), 1);
    add("stream_drain", 0, 0, '0, 1, 1, 0, FD, 1);
    // Stall with A=0x10, B=0x20
`ifdef PIPE_STAGE_SKID_EN
    add("stall_a",    0, 1, DW'('h10), 0, 1, 1, DW'('h10), 1);
    add("stall_b",    0, 1, DW'('h20), 0, 1, 1, DW'('h10), 0);
    add("stall_hold", 0, 0, '0,        0, 0, 1, DW'('h10), 0);
    add("stall_outa", 0, 0, '0,        1, 0, 1, DW'('h20), 1);
    add("stall_outb", 0, 0, '0,        1, 1, 0, FD,        1);
`else
    add("stall_a",    0, 1, DW'('h10), 0, 1, 1, DW'('h10), 0);
    add("stall_b",    0, 1, DW'('h20), 0, 0, 1, DW'('h10), 0);
    add("stall_outa", 0, 1, DW'('h20), 1, 1, 1, DW'('h20), 1);
    add("stall_outb", 0, 0, '0,        1, 1, 0, FD,        1);
`endif

    in_cnt = 0;
    out_cnt = 0;
    foreach (vecs[i]) begin
      drive(vecs[i].flush, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      #1;
      chk({vecs[i].name, "_ir_pre"}, in_ready_o, vecs[i].ir_pre);
      if (in_valid_i && in_ready_o) in_cnt++;
      if (out_valid_o && out_ready_i) out_cnt++;
      @(posedge cpu_clk);
      #1;
      chk({vecs[i].name, "_ov"}, out_valid_o, vecs[i].ov);
      chk({vecs[i].name, "_od"}, out_data_o, vecs[i].od);
      chk({vecs[i].name, "_ir"}, in_ready_o, vecs[i].ir);
    end
    chk("table_in_xfers", DW'(in_cnt), DW'(10));
    chk("table_out_xfers", DW'(out_cnt), DW'(10));

    // Flush with a concurrent input offer: 0x30 must be discarded
`ifdef PIPE_STAGE_SKID_EN
    cyc(1'b0, 1'b1, DW'('h10), 1'b0);
    cyc(1'b0, 1'b1, DW'('h20), 1'b0);
    chk("fl_pre_ir", in_ready_o, 0);
    cyc(1'b1, 1'b1, DW'('h30), 1'b0);
`else
    cyc(1'b0, 1'b1, DW'('h10), 1'b0);
    cyc(1'b1, 1'b1, DW'('h30), 1'b1);
`endif
    chk("fl_ov", out_valid_o, 0);
    chk("fl_od", out_data_o, FD);
    chk("fl_ir", in_ready_o, 1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("fl_after_ov", out_valid_o, 0);
    chk("fl_after_od", out_data_o, FD);

    // Reset mid-operation while holding 0xAB
    cyc(1'b0, 1'b1, DW'('hAB), 1'b0);
    chk("mr_hold_od", out_data_o, DW'('hAB));
    cpu_rst_n = 1'b0;
    cyc(1'b1, 1'b1, DW'('hCD), 1'b1);
    cyc(1'b0, 1'b1, DW'('hCD), 1'b1);
    chk("mr_ov", out_valid_o, 0);
    chk("mr_od", out_data_o, FD);
    chk("mr_ir", in_ready_o, 0);
    cpu_rst_n = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0);
    #1;
    chk("mr_rel_ir_pre", in_ready_o, 0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    chk("mr_rel_ir", in_ready_o, 1);
    chk("mr_rel_ov", out_valid_o, 0);

    // Random scoreboard
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      logic f, iv, ordy, exp_ir;
      logic [DW-1:0] d;
      f = ($urandom_range(99) < 2);
      iv = 1'($urandom);
      ordy = f ? 1'b0 : 1'($urandom);
      d = {$urandom, $urandom, $urandom};
      drive(f, iv, d, ordy);
      #1;
`ifdef PIPE_STAGE_SKID_EN
      exp_ir = (q.size() < 2);
`else
      exp_ir = (q.size() == 0) || ordy;
`endif
      chk("rnd_ov", out_valid_o, (q.size() != 0));
      chk("rnd_ir", in_ready_o, exp_ir);
      if (q.size() == 0) chk("rnd_empty_od", out_data_o, FD);
      if (f) begin
        q.delete();
      end else begin
        if (q.size() != 0 && ordy) begin
          chk("rnd_od", out_data_o, q[0]);
          void'(q.pop_front());
        end
        if (iv && exp_ir) q.push_back(d);
      end
      @(posedge cpu_clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 96, payload width (PC, PC+4, INST for IF/ID).
REQ-002 SHALL have parameter FLUSH_DATA, default 0, value driven on out_data_o when the stage is empty or flushed.
REQ-003 SHALL have port cpu_clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port cpu_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port flush_i  input  1  discard all held entries.
REQ-006 SHALL have port in_valid_i  input  1  upstream payload valid.
REQ-007 SHALL have port in_ready_o  output  1  stage can accept a payload.
REQ-008 SHALL have port in_data_i  input  DATA_WIDTH  upstream payload.
REQ-009 SHALL have port out_valid_o  output  1  downstream payload valid.
REQ-010 SHALL have port out_ready_i  input  1  downstream accepts; low means stall.
REQ-011 SHALL have port out_data_o  output  DATA_WIDTH  registered payload.

Function
REQ-012 SHALL count an input transfer when in_valid_i && in_ready_o at a clock edge, and an output transfer when out_valid_o && out_ready_i.
REQ-013 SHALL keep a main register driving out_data_o and one skid register, controlled by FSM states EMPTY (none held), ONE (main held), TWO (main and skid held).
REQ-014 SHALL make payload latency 1 cycle from input transfer to out_valid_o in EMPTY, with sustained throughput of 1 transfer/cycle.
REQ-015 SHALL drive in_ready_o from a flop: high in EMPTY and ONE, low in TWO; no combinational path from out_ready_i to in_ready_o.
REQ-016 SHALL transition: EMPTY+in -> ONE; ONE+in, no out -> TWO (payload to skid); ONE+in+out -> ONE (main reloaded); ONE+out, no in -> EMPTY; TWO+out -> ONE (skid moves to main); TWO, no out -> TWO, both held.
REQ-017 SHALL hold out_data_o and out_valid_o stable while out_valid_o && !out_ready_i, and never drop or duplicate a payload.
REQ-018 SHALL preserve order: skid contents always leave before any later input.
REQ-019 SHALL give flush_i priority over every other event: next state EMPTY, out_valid_o=0, out_data_o=FLUSH_DATA, skid cleared, and any input transfer in the same cycle discarded.
REQ-020 SHALL drive out_data_o=FLUSH_DATA whenever the state is EMPTY.
REQ-021 SHALL ignore in_data_i when in_valid_i is low and ignore out_ready_i when out_valid_o is low.

Reset
REQ-022 SHALL, on a clock edge with cpu_rst_n low, set state EMPTY, out_valid_o=0, out_data_o=FLUSH_DATA, skid=FLUSH_DATA and in_ready_o=0.
REQ-023 SHALL raise in_ready_o on the first edge after cpu_rst_n goes high.
REQ-024 SHALL let reset override flush_i and all handshakes, and discard held payloads when asserted mid-operation.

Configuration
REQ-025 SHALL, with PIPE_STAGE_SKID_EN defined, implement the skid register and all three states as above.
REQ-026 SHALL, without PIPE_STAGE_SKID_EN, omit the skid register and state TWO, and drive in_ready_o = !out_valid_o || out_ready_i combinationally (in_ready_o still 0 during reset). Latency, flush and reset behaviour stay unchanged.

Structure
REQ-027 SHALL place the FSM state enum (EMPTY, ONE, TWO) and a DATA_WIDTH default localparam in a shared package pipe_pkg.
REQ-028 SHALL be a single module with no sub-modules.

Verification
REQ-029 SHALL cover streaming: out_ready_i=1, payloads 0x1..0x8 on consecutive cycles -> identical values out 1 cycle later, 8 transfers in 8 cycles, in_ready_o constantly 1.
REQ-030 SHALL cover stall: out_ready_i=0 with A=0x10 then B=0x20 offered -> state TWO, in_ready_o=0, out_data_o=0x10 held; then out_ready_i=1 -> 0x10 then 0x20 out on consecutive cycles, in_ready_o=1 again.
REQ-031 SHALL cover flush: in TWO (0x10, 0x20) assert flush_i with in_valid_i=1 and data 0x30 -> next cycle out_valid_o=0, out_data_o=FLUSH_DATA, in_ready_o=1, and 0x30 never appears.
REQ-032 SHALL cover reset mid-operation: state ONE holding 0xAB, cpu_rst_n=0 for 2 cycles -> out_valid_o=0, out_data_o=FLUSH_DATA, in_ready_o=0; first edge after release -> in_ready_o=1.
REQ-033 SHALL cover a random scoreboard: 10k cycles of random in_valid_i/out_ready_i (50%), flush_i at 2% -> output sequence equals input sequence minus flushed entries, with no loss and no duplication.
REQ-034 SHALL cover the build without PIPE_STAGE_SKID_EN: the REQ-030 stimulus -> in_ready_o falls in the same cycle out_ready_i=0 with out_valid_o=1, and B is accepted only after A leaves.
